wave_switcher: RTL and testbench
================================

WAVE_SWITCHER -- requirements
Module: wave_switcher

Interface
REQ-001 Parameter NCH, 8, number of input waveform channels (2..16).
REQ-002 Parameter W, 8, sample width; samples are unsigned offset-binary, midscale MID = 2^(W-1).
REQ-003 Parameter FADE_LOG2, 2, crossfade length is 2^FADE_LOG2 sample ticks (0..6; 0 = no fade).
REQ-004 Parameter ZC_TIMEOUT, 15, maximum sample ticks spent waiting for a zero crossing (1..1023).
REQ-005 clk  in  1  single system clock, all logic rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 sample_en  in  1  one-cycle sample tick; all output updates occur only on ticks.
REQ-008 wave_in  in  NCH*W  packed channels; channel i occupies bits [i*W +: W].
REQ-009 sel  in  clog2(NCH)  requested channel.
REQ-010 sel_load  in  1  one-cycle strobe capturing sel.
REQ-011 wave_out  out  W  registered output sample.
REQ-012 out_valid  out  1  one-cycle pulse marking a new wave_out.
REQ-013 active_sel  out  clog2(NCH)  channel currently driving wave_out (old channel until a switch completes).
REQ-014 busy  out  1  high while in WAIT_ZC or FADE.

Function
REQ-015 States: STEADY, WAIT_ZC, FADE; all updates registered; wave_out and out_valid appear one clk after the sample_en cycle.
REQ-016 STEADY: each tick -> wave_out = wave_in[active_sel], out_valid = 1.
REQ-017 sel_load with sel == active_sel, or sel >= NCH: ignored, no state change.
REQ-018 sel_load in STEADY with valid different sel: latch pending = sel, zc/timeout counter = 0, go WAIT_ZC next cycle.
REQ-019 WAIT_ZC: output continues from active_sel; rising crossing = previous active sample < MID and current >= MID.
REQ-020 WAIT_ZC exits to FADE (fade_k = 0) on the tick detecting a crossing, or on the tick where the counter reaches ZC_TIMEOUT; the counter increments once per tick.
REQ-021 sel_load in WAIT_ZC: valid sel != active_sel replaces pending (counter not reset); sel == active_sel cancels -> STEADY.
REQ-022 FADE: each tick wave_out = (old*(2^F - k) + new*k) >> F, where F = FADE_LOG2, old = wave_in[active_sel], new = wave_in[pending], k = fade_k; intermediate width W+F+1, result truncated, never exceeds 2^W-1.
REQ-023 On the tick with k = 2^F-1: active_sel <= pending, go STEADY; the next tick outputs pure new channel.
REQ-024 FADE_LOG2 = 0: WAIT_ZC exit sets active_sel = pending directly and goes to STEADY.
REQ-025 sel_load in FADE: queued (last one wins); at fade completion, a queued sel differing from the new active_sel enters WAIT_ZC, otherwise it is discarded.
REQ-026 sel_load coincident with fade-completion tick: captured into queue, then REQ-025 applies.
REQ-027 No sample_en: all outputs hold, out_valid = 0, counters frozen.

Reset
REQ-028 rst asserted (any time, incl. mid-fade) -> wave_out = MID, out_valid = 0, active_sel = 0, busy = 0, state STEADY, pending/queue/counters cleared; first tick after release outputs channel 0.

Structure
REQ-029 Shared package wave_pkg holds the state enum, the MID constant function and default NCH/W values.
REQ-030 Crossfade arithmetic (REQ-022) is a combinational sub-module wave_crossfade (old, new, k -> mix).

Verification (NCH=8, W=8, FADE_LOG2=2, ZC_TIMEOUT=15, sample_en every cycle unless stated)
REQ-031 ch0 = 0x55 constant -> wave_out = 0x55 every cycle, out_valid high each tick, busy 0.
REQ-032 ch0 = 0x40, ch3 = 0xC0, sel_load sel=3 -> busy; after 15 ticks outputs 0x40,0x60,0x80,0xA0 then 0xC0, active_sel = 3, busy 0.
REQ-033 ch0 sequence 0x7E,0x7F,0x80, ch1 = 0x20, sel_load sel=1 before 0x7E -> FADE starts on the 0x80 tick, no timeout, active_sel = 1 after 4 fade ticks.
REQ-034 sel_load sel=0 while active 0 -> busy stays 0; sel_load sel=5 during FADE toward 3 -> after completion re-enters WAIT_ZC targeting 5.
REQ-035 rst pulse at fade tick k=2 -> wave_out = 0x80, active_sel = 0, busy 0 same cycle; resumes ch0 on next tick.
REQ-036 sample_en toggling every 3rd cycle during fade -> outputs hold between ticks, fade takes exactly 4 ticks.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared definitions for the waveform switcher: state encoding, default sizes
// and the offset-binary midscale helper.
package wave_pkg;

  localparam int DEFAULT_NCH = 8;
  localparam int DEFAULT_W   = 8;

  typedef enum logic [1:0] {
    STEADY,
    WAIT_ZC,
    FADE
  } wave_state_t;

  // Midscale of an unsigned offset-binary sample of width w.
  function automatic int mid_value(input int w);
    return 1 << (w - 1);
  endfunction

endpackage

// File: rtl/wave_crossfade.sv
// Linear crossfade between two samples: (old*(2^F - k) + new*k) >> F.
// The intermediate sum is W+F+1 bits wide, so the result never wraps.
module wave_crossfade #(
  parameter int W = 8,
  parameter int F = 2
) (
  input  logic [W-1:0] old_sample,
  input  logic [W-1:0] new_sample,
  input  logic [F:0]   k,
  output logic [W-1:0] mix
);

  localparam int         PW   = W + F + 1;
  localparam logic [F:0] FULL = (F + 1)'(2 ** F);

  logic [F:0]    k_old;
  logic [PW-1:0] acc;

  always_comb begin
    k_old = FULL - k;
    acc   = PW'(old_sample) * PW'(k_old) + PW'(new_sample) * PW'(k);
    mix   = W'(acc >> F);
  end

endmodule

// File: rtl/wave_switcher.sv
// Glitch-free channel switcher: waits for a rising midscale crossing (or a
// timeout) on the active channel, then crossfades to the requested one.
module wave_switcher
  import wave_pkg::*;
#(
  parameter int NCH        = DEFAULT_NCH,
  parameter int W          = DEFAULT_W,
  parameter int FADE_LOG2  = 2,
  parameter int ZC_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic [NCH*W-1:0]         wave_in,
  input  logic [$clog2(NCH)-1:0]   sel,
  input  logic                     sel_load,
  output logic [W-1:0]             wave_out,
  output logic                     out_valid,
  output logic [$clog2(NCH)-1:0]   active_sel,
  output logic                     busy
);

  localparam int             SW   = $clog2(NCH);
  localparam int             CW   = $clog2(ZC_TIMEOUT + 1);
  localparam int             F    = FADE_LOG2;
  localparam logic [W-1:0]   MID  = W'(mid_value(W));
  localparam logic [F:0]     KMAX = (F + 1)'(2 ** F - 1);

  wave_state_t   state_q, state_d;
  logic [SW-1:0] active_d, pending_q, pending_d, queued_q, queued_d;
  logic          queue_valid_q, queue_valid_d;
  logic [CW-1:0] zc_cnt_q, zc_cnt_d;
  logic [F:0]    fade_k_q, fade_k_d;
  logic [W-1:0]  prev_q, prev_d, wave_out_d;
  logic          out_valid_d;

  logic [W-1:0]  old_sample, new_sample, mix;
  logic          load_ok, cancel, crossing, requeue;

  wave_crossfade #(.W(W), .F(F)) u_crossfade (
    .old_sample (old_sample),
    .new_sample (new_sample),
    .k          (fade_k_q),
    .mix        (mix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= STEADY;
      active_sel    <= '0;
      pending_q     <= '0;
      queued_q      <= '0;
      queue_valid_q <= 1'b0;
      zc_cnt_q      <= '0;
      fade_k_q      <= '0;
      prev_q        <= MID;
      wave_out      <= MID;
      out_valid     <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_sel    <= active_d;
      pending_q     <= pending_d;
      queued_q      <= queued_d;
      queue_valid_q <= queue_valid_d;
      zc_cnt_q      <= zc_cnt_d;
      fade_k_q      <= fade_k_d;
      prev_q        <= prev_d;
      wave_out      <= wave_out_d;
      out_valid     <= out_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    active_d      = active_sel;
    pending_d     = pending_q;
    queued_d      = queued_q;
    queue_valid_d = queue_valid_q;
    zc_cnt_d      = zc_cnt_q;
    fade_k_d      = fade_k_q;
    prev_d        = prev_q;
    wave_out_d    = wave_out;
    out_valid_d   = 1'b0;
    requeue       = 1'b0;

    old_sample = wave_in[int'(active_sel)*W +: W];
    new_sample = wave_in[int'(pending_q)*W +: W];
    load_ok    = sel_load && (int'(sel) < NCH) && (sel != active_sel);
    cancel     = sel_load && (sel == active_sel);
    crossing   = (prev_q < MID) && (old_sample >= MID);

    unique case (state_q)
      STEADY: begin
        if (sample_en) begin
          wave_out_d  = old_sample;
          out_valid_d = 1'b1;
        end
        if (load_ok) begin
          pending_d = sel;
          zc_cnt_d  = '0;
          state_d   = WAIT_ZC;
        end
      end

      WAIT_ZC: begin
        if (load_ok) pending_d = sel;
        if (sample_en) begin
          wave_out_d  = old_sample;
          out_valid_d = 1'b1;
          zc_cnt_d    = zc_cnt_q + 1'b1;
          if (crossing || zc_cnt_d == CW'(ZC_TIMEOUT)) begin
            // With no fade length the switch happens at the crossing itself.
            if (F == 0) begin
              active_d = pending_d;
              state_d  = STEADY;
            end else begin
              fade_k_d = '0;
              state_d  = FADE;
            end
          end
        end
        if (cancel) begin
          active_d = active_sel;
          state_d  = STEADY;
        end
      end

      FADE: begin
        if (load_ok) begin
          queued_d      = sel;
          queue_valid_d = 1'b1;
        end
        if (sample_en) begin
          wave_out_d  = mix;
          out_valid_d = 1'b1;
          if (fade_k_q == KMAX) begin
            active_d      = pending_q;
            requeue       = queue_valid_d && (queued_d != pending_q);
            queue_valid_d = 1'b0;
            if (requeue) begin
              pending_d = queued_d;
              zc_cnt_d  = '0;
              state_d   = WAIT_ZC;
            end else begin
              state_d = STEADY;
            end
          end else begin
            fade_k_d = fade_k_q + 1'b1;
          end
        end
      end

      default: state_d = STEADY;
    endcase

    // Crossing history always refers to whichever channel is active after this tick.
    if (sample_en) prev_d = wave_in[int'(active_d)*W +: W];
  end

  always_comb begin
    busy = (state_q != STEADY);
  end

endmodule

// File: tb/tb_wave_switcher.sv
// Directed scenarios plus a randomized run against a behavioural switch model.
module tb_wave_switcher;

  logic        clk;
  logic        rst;
  logic        sample_en;
  logic [63:0] wave_in;
  logic [2:0]  sel;
  logic        sel_load;
  logic [7:0]  wave_out;
  logic        out_valid;
  logic [2:0]  active_sel;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model state for the randomized run.
  int m_active, m_target, m_wait, m_k, m_queue, m_prev, m_out;
  bit m_waiting, m_fading, m_qv, m_valid;

  wave_switcher #(.NCH(8), .W(8), .FADE_LOG2(2), .ZC_TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .wave_in    (wave_in),
    .sel        (sel),
    .sel_load   (sel_load),
    .wave_out   (wave_out),
    .out_valid  (out_valid),
    .active_sel (active_sel),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] v);
    wave_in[ch*8 +: 8] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_en = 1'b0;
    sel_load = 1'b0;
    sel = 3'd0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sample_en = 1'b1;
    sel_load = 1'b0;
    sel = 3'd0;
    wave_in = {$urandom(), $urandom()};
    step();
    checks++;
    if (wave_out !== 8'h80) begin errors++; $display("[TB] FAIL reset_wave_out got %h want 80", wave_out); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (active_sel !== 3'd0) begin errors++; $display("[TB] FAIL reset_active got %0d want 0", active_sel); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_steady();
    rst = 1'b0;
    sample_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wave_in = {$urandom(), $urandom()};
      set_ch(0, 8'h55);
      step();
      checks++;
      if (wave_out !== 8'h55) begin errors++; $display("[TB] FAIL steady_out got %h want 55", wave_out); end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL steady_valid got %b want 1", out_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL steady_busy got %b want 0", busy); end
    end
  endtask

  task automatic test_timeout_fade();
    logic [7:0] fade_exp [4];
    fade_exp[0] = 8'h40; fade_exp[1] = 8'h60; fade_exp[2] = 8'h80; fade_exp[3] = 8'hA0;
    do_reset();
    wave_in = '0;
    set_ch(0, 8'h40);
    set_ch(3, 8'hC0);
    sample_en = 1'b1;
    step();
    sel = 3'd3;
    sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL timeout_busy_start got %b want 1", busy); end
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if (wave_out !== 8'h40 || busy !== 1'b1)
        begin errors++; $display("[TB] FAIL timeout_wait tick %0d got %h/%b want 40/1", i, wave_out, busy); end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (wave_out !== fade_exp[i])
        begin errors++; $display("[TB] FAIL timeout_fade k=%0d got %h want %h", i, wave_out, fade_exp[i]); end
      if (i < 3) begin
        checks++;
        if (active_sel !== 3'd0 || busy !== 1'b1)
          begin errors++; $display("[TB] FAIL timeout_fade_active k=%0d got %0d/%b want 0/1", i, active_sel, busy); end
      end
    end
    checks++;
    if (active_sel !== 3'd3 || busy !== 1'b0)
      begin errors++; $display("[TB] FAIL timeout_done got %0d/%b want 3/0", active_sel, busy); end
    step();
    checks++;
    if (wave_out !== 8'hC0) begin errors++; $display("[TB] FAIL timeout_new_ch got %h want c0", wave_out); end
  endtask

  task automatic test_zero_cross();
    logic [7:0] ramp [3];
    logic [7:0] fade_exp [4];
    ramp[0] = 8'h7E; ramp[1] = 8'h7F; ramp[2] = 8'h80;
    fade_exp[0] = 8'h80; fade_exp[1] = 8'h68; fade_exp[2] = 8'h50; fade_exp[3] = 8'h38;
    do_reset();
    wave_in = '0;
    set_ch(0, 8'h70);
    set_ch(1, 8'h20);
    sample_en = 1'b1;
    step();
    sel = 3'd1;
    sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ch(0, ramp[i]);
      step();
      checks++;
      if (wave_out !== ramp[i] || busy !== 1'b1)
        begin errors++; $display("[TB] FAIL zc_wait %0d got %h/%b want %h/1", i, wave_out, busy, ramp[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (wave_out !== fade_exp[i])
        begin errors++; $display("[TB] FAIL zc_fade k=%0d got %h want %h", i, wave_out, fade_exp[i]); end
    end
    checks++;
    if (active_sel !== 3'd1 || busy !== 1'b0)
      begin errors++; $display("[TB] FAIL zc_done got %0d/%b want 1/0", active_sel, busy); end
    step();
    checks++;
    if (wave_out !== 8'h20) begin errors++; $display("[TB] FAIL zc_new_ch got %h want 20", wave_out); end
  endtask

  task automatic test_queue();
    int  n;
    bit  done;
    do_reset();
    wave_in = '0;
    set_ch(0, 8'h40);
    set_ch(3, 8'hC0);
    set_ch(5, 8'h10);
    sample_en = 1'b1;
    step();
    sel = 3'd0;
    sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL same_sel_busy got %b want 0", busy); end
    sel = 3'd3;
    sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    repeat (15) step();
    sel = 3'd5;
    sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    repeat (3) step();
    checks++;
    if (active_sel !== 3'd3 || busy !== 1'b1)
      begin errors++; $display("[TB] FAIL queue_reenter got %0d/%b want 3/1", active_sel, busy); end
    done = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
      done = (active_sel == 3'd5) && !busy;
    end
    checks++;
    if (!done) begin errors++; $display("[TB] FAIL queue_target got %0d/%b want 5/0 within 40 ticks", active_sel, busy); end
    step();
    checks++;
    if (wave_out !== 8'h10) begin errors++; $display("[TB] FAIL queue_out got %h want 10", wave_out); end
  endtask

  task automatic test_reset_mid_fade();
    do_reset();
    wave_in = '0;
    set_ch(0, 8'h40);
    set_ch(3, 8'hC0);
    sample_en = 1'b1;
    step();
    sel = 3'd3;
    sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    repeat (17) step();
    checks++;
    if (wave_out !== 8'h60) begin errors++; $display("[TB] FAIL midfade_pre got %h want 60", wave_out); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (wave_out !== 8'h80 || out_valid !== 1'b0)
      begin errors++; $display("[TB] FAIL midfade_rst_out got %h/%b want 80/0", wave_out, out_valid); end
    checks++;
    if (active_sel !== 3'd0 || busy !== 1'b0)
      begin errors++; $display("[TB] FAIL midfade_rst_state got %0d/%b want 0/0", active_sel, busy); end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (wave_out !== 8'h40 || out_valid !== 1'b1 || active_sel !== 3'd0)
      begin errors++; $display("[TB] FAIL midfade_resume got %h/%b/%0d want 40/1/0", wave_out, out_valid, active_sel); end
  endtask

  task automatic test_sparse_ticks();
    logic [7:0] fade_exp [4];
    logic [7:0] last, exp_out;
    int ticks, cyc;
    fade_exp[0] = 8'h40; fade_exp[1] = 8'h60; fade_exp[2] = 8'h80; fade_exp[3] = 8'hA0;
    do_reset();
    wave_in = '0;
    set_ch(0, 8'h40);
    set_ch(3, 8'hC0);
    sample_en = 1'b1;
    step();
    sel = 3'd3;
    sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    last = 8'h40;
    ticks = 0;
    cyc = 0;
    while (ticks < 19 && cyc < 100) begin
      sample_en = (cyc % 3 == 0);
      step();
      if (sample_en) begin
        ticks++;
        exp_out = (ticks <= 15) ? 8'h40 : fade_exp[ticks-16];
        checks++;
        if (wave_out !== exp_out || out_valid !== 1'b1)
          begin errors++; $display("[TB] FAIL sparse_tick %0d got %h/%b want %h/1", ticks, wave_out, out_valid, exp_out); end
        checks++;
        if (busy !== (ticks < 19))
          begin errors++; $display("[TB] FAIL sparse_busy tick %0d got %b want %b", ticks, busy, ticks < 19); end
        last = exp_out;
      end else begin
        checks++;
        if (wave_out !== last || out_valid !== 1'b0)
          begin errors++; $display("[TB] FAIL sparse_hold cyc %0d got %h/%b want %h/0", cyc, wave_out, out_valid, last); end
      end
      cyc++;
    end
    checks++;
    if (active_sel !== 3'd3) begin errors++; $display("[TB] FAIL sparse_active got %0d want 3", active_sel); end
    sample_en = 1'b1;
    step();
    checks++;
    if (wave_out !== 8'hC0) begin errors++; $display("[TB] FAIL sparse_new_ch got %h want c0", wave_out); end
  endtask

  // One clock of the switching behaviour, described as channel/transition bookkeeping.
  task automatic model_step(input bit en, input bit load, input int s, input logic [63:0] win);
    int cur, nxt;
    bit go;
    cur = int'(win[m_active*8 +: 8]);
    nxt = int'(win[m_target*8 +: 8]);
    m_valid = en;
    if (!m_waiting && !m_fading) begin
      if (en) m_out = cur;
      if (load && s != m_active) begin
        m_waiting = 1'b1;
        m_target = s;
        m_wait = 0;
      end
    end else if (m_waiting) begin
      go = 1'b0;
      if (en) begin
        m_out = cur;
        m_wait++;
        go = (m_prev < 128 && cur >= 128) || (m_wait == 15);
      end
      if (load && s == m_active) begin
        m_waiting = 1'b0;
      end else begin
        if (load) m_target = s;
        if (go) begin
          m_waiting = 1'b0;
          m_fading = 1'b1;
          m_k = 0;
        end
      end
    end else begin
      if (load && s != m_active) begin
        m_qv = 1'b1;
        m_queue = s;
      end
      if (en) begin
        m_out = (cur * (4 - m_k) + nxt * m_k) / 4;
        if (m_k == 3) begin
          m_fading = 1'b0;
          m_active = m_target;
          if (m_qv && m_queue != m_active) begin
            m_waiting = 1'b1;
            m_target = m_queue;
            m_wait = 0;
          end
          m_qv = 1'b0;
        end else begin
          m_k++;
        end
      end
    end
    if (en) m_prev = int'(win[m_active*8 +: 8]);
  endtask

  task automatic test_random();
    do_reset();
    m_active = 0; m_target = 0; m_wait = 0; m_k = 0; m_queue = 0;
    m_prev = 128; m_out = 128;
    m_waiting = 1'b0; m_fading = 1'b0; m_qv = 1'b0; m_valid = 1'b0;
    wave_in = {$urandom(), $urandom()};
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) wave_in = {$urandom(), $urandom()};
      sample_en = ($urandom_range(0, 2) != 0);
      sel_load = ($urandom_range(0, 7) == 0);
      sel = 3'($urandom_range(0, 7));
      model_step(sample_en, sel_load, int'(sel), wave_in);
      step();
      checks++;
      if (wave_out !== 8'(m_out) || out_valid !== m_valid)
        begin errors++; $display("[TB] FAIL rand_out cyc %0d got %h/%b want %h/%b", i, wave_out, out_valid, 8'(m_out), m_valid); end
      checks++;
      if (active_sel !== 3'(m_active) || busy !== (m_waiting || m_fading))
        begin errors++; $display("[TB] FAIL rand_state cyc %0d got %0d/%b want %0d/%b", i, active_sel, busy, m_active, m_waiting || m_fading); end
    end
  endtask

  initial begin
    rst = 1'b1;
    sample_en = 1'b0;
    sel_load = 1'b0;
    sel = 3'd0;
    wave_in = '0;
    test_reset();
    test_steady();
    test_timeout_fade();
    test_zero_cross();
    test_queue();
    test_reset_mid_fade();
    test_sparse_ticks();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
